// File: rtl/uart_result_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_result_framer                                                          |
// | Frames one classifier result (class + score) into a 6-byte, sequence-      |
// | numbered, checksummed packet and feeds it byte-wise to a UART transmitter.  |
// | Optional: define FRAMER_CRC8_EN for a CRC-8 check byte instead of XOR.      |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module uart_result_framer #(
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid_i,
  input  logic [7:0]  res_class_i,
  input  logic [15:0] res_score_i,
  output logic        res_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        frame_busy_o,
  output logic        frame_done_o,
  output logic        frame_err_o
);

  // The ack counter only has to reach ACK_TIMEOUT-2: the abort decision is
  // taken in the cycle whose increment would make it ACK_TIMEOUT-1.
  localparam int unsigned        c_cnt_w    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT - 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 2);
  localparam logic [2:0]         c_last_idx = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           idx_q, idx_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [7:0]           seq_q, seq_d;
  logic [7:0]           class_q, class_d;
  logic [15:0]          score_q, score_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [2:0]           w_next_idx;
  logic [7:0]           w_next_byte;
  logic [7:0]           w_chk;

`ifdef FRAMER_CRC8_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  assign w_chk = crc8_byte(crc8_byte(crc8_byte(crc8_byte(8'h00, seq_q), class_q),
                                     score_q[15:8]), score_q[7:0]);
`else
  assign w_chk = seq_q ^ class_q ^ score_q[15:8] ^ score_q[7:0];
`endif

  assign w_next_idx = idx_q + 3'd1;

  always_comb begin
    w_next_byte = HEADER_BYTE;
    case (w_next_idx)
      3'd1:    w_next_byte = seq_q;
      3'd2:    w_next_byte = class_q;
      3'd3:    w_next_byte = score_q[15:8];
      3'd4:    w_next_byte = score_q[7:0];
      3'd5:    w_next_byte = w_chk;
      default: w_next_byte = HEADER_BYTE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    class_d   = class_q;
    score_d   = score_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (res_valid_i) begin
          class_d   = res_class_i;
          score_d   = res_score_i;
          idx_d     = 3'd0;
          tx_data_d = HEADER_BYTE;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == c_cnt_last) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        // tx_data is loaded on the way into SEND so it stays put between starts.
        if (!tx_busy_i) begin
          if (idx_q == c_last_idx) begin
            done_d  = 1'b1;
            seq_d   = seq_q + 8'd1;
            state_d = S_IDLE;
          end else begin
            idx_d     = w_next_idx;
            tx_data_d = w_next_byte;
            state_d   = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      seq_q     <= 8'h00;
      class_q   <= 8'h00;
      score_q   <= 16'h0000;
      tx_data_q <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      class_q   <= class_d;
      score_q   <= score_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign res_ready_o  = (state_q == S_IDLE);
  assign frame_busy_o = (state_q != S_IDLE);
  assign tx_start_o   = (state_q == S_SEND);
  assign tx_data_o    = tx_data_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_result_framer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for uart_result_framer: randomized results against a frame-level
// reference model, with a behavioural UART transmitter driving tx_busy.
module tb_uart_result_framer;

  localparam logic [7:0] HDR    = 8'hA5;
  localparam int         ACK_TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [7:0]  res_class = 8'h00;
  logic [15:0] res_score = 16'h0000;
  logic        res_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        frame_busy, frame_done, frame_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_seq = 8'h00;

  int busy_len = 20;
  bit uart_en  = 1'b1;
  int busy_cnt = 0;
  bit pend     = 1'b0;

  logic [7:0] tx_log[$];
  int n_start = 0, n_done = 0, n_err = 0, n_start_busy = 0, n_overlap = 0, n_ready_busy = 0;

  uart_result_framer #(.HEADER_BYTE(HDR), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst),
    .res_valid_i(res_valid), .res_class_i(res_class), .res_score_i(res_score),
    .res_ready_o(res_ready), .tx_data_o(tx_data), .tx_start_o(tx_start),
    .tx_busy_i(tx_busy), .frame_busy_o(frame_busy),
    .frame_done_o(frame_done), .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  // Observation plus UART model: busy rises the cycle after a start and stays
  // high for busy_len cycles; it ignores rst so a byte in flight completes.
  always @(negedge clk) begin
    if (tx_start) begin
      n_start++;
      tx_log.push_back(tx_data);
      if (tx_busy) n_start_busy++;
      if (frame_done || frame_err) n_overlap++;
    end
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_done && frame_err) n_overlap++;
    if (frame_busy && res_ready) n_ready_busy++;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    if (pend) begin
      pend = 1'b0;
      tx_busy = 1'b1;
      busy_cnt = busy_len;
    end
    if (tx_start && uart_en) pend = 1'b1;
  end

  // Expected frame {hdr, seq, class, score_hi, score_lo, chk}, byte 0 in the MSBs.
  function automatic logic [47:0] model_frame(input logic [7:0] seq, input logic [7:0] cls,
                                              input logic [15:0] sc);
    logic [31:0] body;
    logic [7:0]  chk;
`ifdef FRAMER_CRC8_EN
    logic fb;
`endif
    body = {seq, cls, sc};
`ifdef FRAMER_CRC8_EN
    chk = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = chk[7] ^ body[i];
      chk = {chk[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
`else
    chk = body[31:24] ^ body[23:16] ^ body[15:8] ^ body[7:0];
`endif
    return {HDR, body, chk};
  endfunction

  task automatic clear_obs;
    tx_log.delete();
    n_start = 0; n_done = 0; n_err = 0; n_start_busy = 0; n_overlap = 0; n_ready_busy = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_seq = 8'h00;
  endtask

  task automatic send_result(input logic [7:0] cls, input logic [15:0] sc, output bit ok);
    res_class = cls;
    res_score = sc;
    res_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (res_ready) ok = 1'b1;
      @(negedge clk);
    end
    res_valid = 1'b0;
  endtask

  task automatic wait_frame_end(output int st);
    st = 0;
    for (int i = 0; i < 20000 && st == 0; i++) begin
      if (frame_done) st = 1;
      else if (frame_err) st = 2;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    res_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (res_ready !== 1'b1)   $display("FAIL reset_res_ready: got %b expected 1", res_ready);   else checks += 0;
    if (res_ready !== 1'b1) errors++;
    checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (tx_start !== 1'b0)    begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++; if (frame_busy !== 1'b0)  begin errors++; $display("FAIL reset_frame_busy: got %b expected 0", frame_busy); end
    checks++; if (frame_done !== 1'b0)  begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    rst = 1'b0;
    res_valid = 1'b0;
    exp_seq = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok; int st; logic [47:0] f, lit;
`ifdef FRAMER_CRC8_EN
    lit = 48'hA5_00_03_12_34_4C;
`else
    lit = 48'hA5_00_03_12_34_25;
`endif
    do_reset;
    busy_len = 20; uart_en = 1'b1;
    clear_obs;
    send_result(8'h03, 16'h1234, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_transfer: got no transfer expected one"); end
    checks++; if (res_ready !== 1'b0 || frame_busy !== 1'b1) begin errors++;
      $display("FAIL basic_after_transfer: got ready=%b busy=%b expected ready=0 busy=1", res_ready, frame_busy); end
    wait_frame_end(st);
    checks++; if (st != 1) begin errors++; $display("FAIL basic_end: got status %0d expected 1", st); end
    checks++; if (res_ready !== 1'b1 || frame_busy !== 1'b0 || tx_start !== 1'b0) begin errors++;
      $display("FAIL basic_idle_at_done: got ready=%b busy=%b start=%b expected 1 0 0", res_ready, frame_busy, tx_start); end
    @(negedge clk);
    f = model_frame(exp_seq, 8'h03, 16'h1234);
    exp_seq++;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] got;
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== f[47-8*i -: 8]) begin errors++;
        $display("FAIL basic_byte%0d: got %h expected %h", i, got, f[47-8*i -: 8]); end
      checks++; if (got !== lit[47-8*i -: 8]) begin errors++;
        $display("FAIL basic_literal%0d: got %h expected %h", i, got, lit[47-8*i -: 8]); end
    end
    checks++; if (n_start != 6) begin errors++; $display("FAIL basic_starts: got %0d expected 6", n_start); end
    checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL basic_pulses: got done=%0d err=%0d expected 1 0", n_done, n_err); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected 0", frame_done); end
    checks++; if (n_start_busy != 0 || n_overlap != 0 || n_ready_busy != 0) begin errors++;
      $display("FAIL basic_protocol: got start_busy=%0d overlap=%0d ready_busy=%0d expected 0", n_start_busy, n_overlap, n_ready_busy); end
    checks++; if (tx_data !== f[7:0]) begin errors++; $display("FAIL basic_data_hold: got %h expected %h", tx_data, f[7:0]); end
  endtask

  task automatic test_random;
    bit ok; int st; logic [47:0] f; logic [7:0] cls; logic [15:0] sc;
    for (int n = 0; n < 20; n++) begin
      cls = 8'($urandom); sc = 16'($urandom);
      busy_len = $urandom_range(1, 8);
      clear_obs;
      send_result(cls, sc, ok);
      wait_frame_end(st);
      @(negedge clk);
      f = model_frame(exp_seq, cls, sc);
      exp_seq++;
      checks++; if (!ok || st != 1) begin errors++; $display("FAIL random_frame%0d: got ok=%0b st=%0d expected 1 1", n, ok, st); end
      for (int i = 0; i < 6; i++) begin
        logic [7:0] got;
        got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
        checks++; if (got !== f[47-8*i -: 8]) begin errors++;
          $display("FAIL random%0d_byte%0d: got %h expected %h", n, i, got, f[47-8*i -: 8]); end
      end
      checks++; if (n_start_busy != 0 || n_overlap != 0) begin errors++;
        $display("FAIL random%0d_protocol: got start_busy=%0d overlap=%0d expected 0", n, n_start_busy, n_overlap); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok, seen, ready_at_done; int st;
    logic [7:0] cls_a, cls_b; logic [15:0] sc_a, sc_b; logic [47:0] f1, f2;
    clear_obs;
    busy_len = $urandom_range(2, 6);
    cls_a = 8'($urandom); sc_a = 16'($urandom);
    cls_b = 8'hxx; sc_b = 16'hxxxx; ready_at_done = 1'b0;
    res_class = cls_a; res_score = sc_a; res_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (res_ready) ok = 1'b1;
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_transfer: got none expected one"); end
    seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      if (frame_done) begin
        seen = 1'b1; cls_b = res_class; sc_b = res_score; ready_at_done = res_ready;
      end else begin
        res_class = cls_a ^ 8'($urandom_range(1, 255));
        res_score = 16'($urandom);
        @(negedge clk);
      end
    end
    checks++; if (!seen || !ready_at_done) begin errors++;
      $display("FAIL b2b_ready_at_done: got seen=%b ready=%b expected 1 1", seen, ready_at_done); end
    @(negedge clk);
    checks++; if (frame_busy !== 1'b1) begin errors++; $display("FAIL b2b_second_transfer: got busy=%b expected 1", frame_busy); end
    res_valid = 1'b0; res_class = 8'h00; res_score = 16'h0000;
    wait_frame_end(st);
    @(negedge clk);
    checks++; if (st != 1) begin errors++; $display("FAIL b2b_second_end: got status %0d expected 1", st); end
    f1 = model_frame(exp_seq, cls_a, sc_a);
    f2 = model_frame(8'(exp_seq + 8'd1), cls_b, sc_b);
    exp_seq = 8'(exp_seq + 8'd2);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] got, want;
      got  = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      want = (i < 6) ? f1[47-8*i -: 8] : f2[47-8*(i-6) -: 8];
      checks++; if (got !== want) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got, want); end
    end
    checks++; if (n_start != 12 || n_done != 2 || n_start_busy != 0) begin errors++;
      $display("FAIL b2b_counts: got starts=%0d done=%0d start_busy=%0d expected 12 2 0", n_start, n_done, n_start_busy); end
  endtask

  task automatic test_timeout;
    bit ok; int st, k; logic [47:0] f; logic [7:0] cls; logic [15:0] sc;
    do_reset;
    uart_en = 1'b0;
    clear_obs;
    send_result(8'h5A, 16'hBEEF, ok);
    checks++; if (!ok || tx_start !== 1'b1 || tx_data !== HDR) begin errors++;
      $display("FAIL timeout_first_start: got ok=%b start=%b data=%h expected 1 1 %h", ok, tx_start, tx_data, HDR); end
    k = 0;
    while (!frame_err && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != ACK_TO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", k, ACK_TO); end
    checks++; if (frame_busy !== 1'b0 || res_ready !== 1'b1) begin errors++;
      $display("FAIL timeout_idle: got busy=%b ready=%b expected 0 1", frame_busy, res_ready); end
    @(negedge clk);
    checks++; if (n_start != 1 || n_err != 1 || n_done != 0 || frame_err !== 1'b0) begin errors++;
      $display("FAIL timeout_counts: got starts=%0d err=%0d done=%0d err_now=%b expected 1 1 0 0", n_start, n_err, n_done, frame_err); end
    uart_en = 1'b1;
    busy_len = 3;
    clear_obs;
    cls = 8'($urandom); sc = 16'($urandom);
    send_result(cls, sc, ok);
    wait_frame_end(st);
    @(negedge clk);
    f = model_frame(exp_seq, cls, sc);
    exp_seq++;
    checks++; if (st != 1) begin errors++; $display("FAIL timeout_next_end: got status %0d expected 1", st); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] got;
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== f[47-8*i -: 8]) begin errors++;
        $display("FAIL timeout_next_byte%0d: got %h expected %h", i, got, f[47-8*i -: 8]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok; int st, k; logic [47:0] f; logic [7:0] cls; logic [15:0] sc;
    do_reset;
    busy_len = 20; uart_en = 1'b1;
    clear_obs;
    send_result(8'h11, 16'h2233, ok);
    k = 0;
    while (n_start < 3 && k < 2000) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    checks++; if (frame_busy !== 1'b1 || tx_busy !== 1'b1) begin errors++;
      $display("FAIL midreset_setup: got busy=%b uart=%b expected 1 1", frame_busy, tx_busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (res_ready !== 1'b1 || tx_data !== 8'h00 || tx_start !== 1'b0 ||
                  frame_busy !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin errors++;
      $display("FAIL midreset_outputs: got ready=%b data=%h start=%b busy=%b done=%b err=%b expected 1 00 0 0 0 0",
               res_ready, tx_data, tx_start, frame_busy, frame_done, frame_err); end
    rst = 1'b0;
    exp_seq = 8'h00;
    k = 0;
    while ((tx_busy || pend) && k < 200) begin @(negedge clk); k++; end
    clear_obs;
    cls = 8'($urandom); sc = 16'($urandom);
    send_result(cls, sc, ok);
    wait_frame_end(st);
    @(negedge clk);
    f = model_frame(exp_seq, cls, sc);
    exp_seq++;
    checks++; if (st != 1 || n_start != 6) begin errors++;
      $display("FAIL midreset_next: got status=%0d starts=%0d expected 1 6", st, n_start); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] got;
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== f[47-8*i -: 8]) begin errors++;
        $display("FAIL midreset_byte%0d: got %h expected %h", i, got, f[47-8*i -: 8]); end
    end
  endtask

  task automatic test_seq_wrap;
    bit ok; int st; logic [47:0] f;
    do_reset;
    busy_len = 1; uart_en = 1'b1;
    for (int n = 1; n <= 257; n++) begin
      clear_obs;
      send_result(8'h00, 16'h0000, ok);
      wait_frame_end(st);
      @(negedge clk);
      f = model_frame(exp_seq, 8'h00, 16'h0000);
      exp_seq++;
      for (int i = 0; i < 6; i++) begin
        logic [7:0] got;
        got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
        checks++; if (got !== f[47-8*i -: 8]) begin errors++;
          $display("FAIL wrap%0d_byte%0d: got %h expected %h", n, i, got, f[47-8*i -: 8]); end
      end
      if (n == 256) begin
        checks++; if (tx_log.size() < 2 || tx_log[1] !== 8'hFF) begin errors++;
          $display("FAIL wrap256_seq: got %h expected ff", (tx_log.size() > 1) ? tx_log[1] : 8'hxx); end
`ifndef FRAMER_CRC8_EN
        checks++; if (tx_log.size() < 6 || tx_log[5] !== 8'hFF) begin errors++;
          $display("FAIL wrap256_chk: got %h expected ff", (tx_log.size() > 5) ? tx_log[5] : 8'hxx); end
`endif
      end
      if (n == 257) begin
        checks++; if (tx_log.size() < 6 || tx_log[1] !== 8'h00 || tx_log[5] !== f[7:0]) begin errors++;
          $display("FAIL wrap257: got seq=%h chk=%h expected 00 %h",
                   (tx_log.size() > 1) ? tx_log[1] : 8'hxx, (tx_log.size() > 5) ? tx_log[5] : 8'hxx, f[7:0]); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_basic;
    test_random;
    test_back_to_back;
    test_timeout;
    test_reset_mid_frame;
    test_seq_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
